vx_lane_serializer: RTL and testbench

- Sequences a multi-lane request (per-lane valid mask plus per-lane payload) into one lane per cycle on a valid/ready output port.
- Picks lanes in priority order using an OR prefix scan of the pending mask (instance of VX_scan).
- Sits between warp-wide issue and single-ported shared resources (e.g. per-lane CSR/IO or raytracing unit requests) that accept one lane per cycle.

---
 rtl/vx_lane_serializer_pkg.sv | 15 +
 rtl/vx_lane_serializer_scan.sv | 28 ++
 rtl/vx_lane_serializer.sv | 120 ++++++++++++
 tb/tb_vx_lane_serializer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/vx_lane_serializer_pkg.sv
// Shared types and width helpers for the lane serializer.
// Holds the two-state FSM encoding and the lane-index width rule.
package vx_lane_serializer_pkg;

    typedef enum logic {
        SER_IDLE = 1'b0,
        SER_BUSY = 1'b1
    } ser_state_e;

    // Lane index width: clog2(n), but never narrower than one bit.
    function automatic int lanew_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_lane_serializer_scan.sv
// VX_scan with OP "|": inclusive OR prefix scan.
// REVERSE=0 accumulates from bit 0 upward; REVERSE=1 accumulates from bit N-1 downward.
module VX_scan #(
    parameter int N       = 4,
    parameter int REVERSE = 0
) (
    input  logic [N-1:0] data_in,
    output logic [N-1:0] data_out
);

    always_comb begin
        logic acc;
        acc      = 1'b0;
        data_out = '0;
        if (REVERSE != 0) begin
            for (int i = N - 1; i >= 0; i--) begin
                acc         = acc | data_in[i];
                data_out[i] = acc;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                acc         = acc | data_in[i];
                data_out[i] = acc;
            end
        end
    end

endmodule

// File: rtl/vx_lane_serializer.sv
// Serializes a masked multi-lane request into one lane per cycle on a valid/ready port.
// The last-lane fire and the next request accept can share an edge, so there are no bubbles.
module vx_lane_serializer
    import vx_lane_serializer_pkg::*;
#(
    parameter  int N       = 4,
    parameter  int DATAW   = 32,
    parameter  int REVERSE = 0,
    localparam int LANEW   = lanew_f(N)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_in,
    output logic                 ready_in,
    input  logic [N-1:0]         mask_in,
    input  logic [N*DATAW-1:0]   data_in,
    output logic                 valid_out,
    input  logic                 ready_out,
    output logic [LANEW-1:0]     lane_out,
    output logic [DATAW-1:0]     data_out,
    output logic                 first_out,
    output logic                 last_out
);

    ser_state_e                   state, state_n;
    logic [N-1:0]                 pending, pending_n;
    logic                         first_q, first_n;
    logic [N-1:0][DATAW-1:0]      data_q;
    logic [N-1:0]                 scan, sel;
    logic                         busy, fire, accept, load;

    VX_scan #(
        .N       (N),
        .REVERSE (REVERSE)
    ) scan_inst (
        .data_in  (pending),
        .data_out (scan)
    );

    // Isolate the single highest-priority pending lane from the prefix scan.
    always_comb begin
        if (REVERSE != 0) begin
            sel = scan & ~(scan >> 1);
        end else begin
            sel = scan & ~(scan << 1);
        end
    end

    always_comb begin
        lane_out = '0;
        data_out = '0;
        for (int i = 0; i < N; i++) begin
            if (sel[i]) begin
                lane_out = LANEW'(i);
            end
            data_out = data_out | ({DATAW{sel[i]}} & data_q[i]);
        end
    end

    assign busy      = (state == SER_BUSY);
    assign valid_out = busy;
    assign first_out = busy & first_q;
    assign last_out  = busy & ((pending & ~sel) == '0);
    assign fire      = valid_out & ready_out;
    assign ready_in  = (state == SER_IDLE) | (fire & last_out);
    assign accept    = valid_in & ready_in;

    always_comb begin
        state_n   = state;
        pending_n = pending;
        first_n   = first_q;
        load      = 1'b0;
        case (state)
            SER_IDLE: begin
                state_n = SER_IDLE;
            end
            SER_BUSY: begin
                if (fire) begin
                    pending_n = pending & ~sel;
                    first_n   = 1'b0;
                    if (last_out) begin
                        state_n = SER_IDLE;
                    end
                end
            end
            default: begin
                state_n   = SER_IDLE;
                pending_n = '0;
                first_n   = 1'b0;
            end
        endcase
        // A zero-mask request is consumed silently and leaves the FSM idle.
        if (accept && (mask_in != '0)) begin
            pending_n = mask_in;
            first_n   = 1'b1;
            state_n   = SER_BUSY;
            load      = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= SER_IDLE;
            pending <= '0;
            first_q <= 1'b0;
        end else begin
            state   <= state_n;
            pending <= pending_n;
            first_q <= first_n;
        end
    end

    // Payload is only ever read under a pending lane, so it carries no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            data_q <= data_in;
        end
    end

endmodule

// File: tb/tb_vx_lane_serializer.sv
// Bench for vx_lane_serializer: forward and reverse instances share stimulus and are
// checked against a lane-queue reference model.
module tb_vx_lane_serializer;

    localparam int N     = 4;
    localparam int DATAW = 32;
    localparam int LANEW = 2;

    typedef struct {
        int               lane;
        logic [DATAW-1:0] data;
        bit               first;
        bit               last;
    } lane_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 valid_in;
    logic [N-1:0]         mask_in;
    logic [N*DATAW-1:0]   data_in;
    logic                 ready_out;

    logic                 ready_in_f, valid_out_f, first_out_f, last_out_f;
    logic [LANEW-1:0]     lane_out_f;
    logic [DATAW-1:0]     data_out_f;
    logic                 ready_in_r, valid_out_r, first_out_r, last_out_r;
    logic [LANEW-1:0]     lane_out_r;
    logic [DATAW-1:0]     data_out_r;

    lane_t qf[$];
    lane_t qr[$];
    int    vectors     = 0;
    int    miscompares = 0;

    always #5 clk = ~clk;

    vx_lane_serializer #(.N(N), .DATAW(DATAW), .REVERSE(0)) dut_f (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .ready_in  (ready_in_f),
        .mask_in   (mask_in),
        .data_in   (data_in),
        .valid_out (valid_out_f),
        .ready_out (ready_out),
        .lane_out  (lane_out_f),
        .data_out  (data_out_f),
        .first_out (first_out_f),
        .last_out  (last_out_f)
    );

    vx_lane_serializer #(.N(N), .DATAW(DATAW), .REVERSE(1)) dut_r (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .ready_in  (ready_in_r),
        .mask_in   (mask_in),
        .data_in   (data_in),
        .valid_out (valid_out_r),
        .ready_out (ready_out),
        .lane_out  (lane_out_r),
        .data_out  (data_out_r),
        .first_out (first_out_r),
        .last_out  (last_out_r)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Expand an accepted request into the ordered list of lanes it must produce.
    task automatic push_req(input logic [N-1:0] m, input logic [N*DATAW-1:0] d);
        lane_t e;
        int    total;
        int    cnt;
        total = $countones(m);
        cnt = 0;
        for (int i = 0; i < N; i++) begin
            if (m[i]) begin
                cnt++;
                e.lane = i; e.data = d[i*DATAW +: DATAW];
                e.first = (cnt == 1); e.last = (cnt == total);
                qf.push_back(e);
            end
        end
        cnt = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (m[i]) begin
                cnt++;
                e.lane = i; e.data = d[i*DATAW +: DATAW];
                e.first = (cnt == 1); e.last = (cnt == total);
                qr.push_back(e);
            end
        end
    endtask

    task automatic cycle(input logic v, input logic [N-1:0] m,
                         input logic [N*DATAW-1:0] d, input logic r);
        bit exp_rdy;
        @(negedge clk);
        valid_in = v; mask_in = m; data_in = d; ready_out = r;
        #1;
        chk("valid_f", 64'(valid_out_f), 64'(qf.size() != 0));
        chk("valid_r", 64'(valid_out_r), 64'(qr.size() != 0));
        if (qf.size() != 0) begin
            chk("lane_f",  64'(lane_out_f),  64'(qf[0].lane));
            chk("data_f",  64'(data_out_f),  64'(qf[0].data));
            chk("first_f", 64'(first_out_f), 64'(qf[0].first));
            chk("last_f",  64'(last_out_f),  64'(qf[0].last));
        end
        if (qr.size() != 0) begin
            chk("lane_r",  64'(lane_out_r),  64'(qr[0].lane));
            chk("data_r",  64'(data_out_r),  64'(qr[0].data));
            chk("first_r", 64'(first_out_r), 64'(qr[0].first));
            chk("last_r",  64'(last_out_r),  64'(qr[0].last));
        end
        exp_rdy = (qf.size() == 0) || (r && qf.size() == 1);
        chk("ready_in_f", 64'(ready_in_f), 64'(exp_rdy));
        chk("ready_in_r", 64'(ready_in_r), 64'(exp_rdy));
        if (r && qf.size() != 0) void'(qf.pop_front());
        if (r && qr.size() != 0) void'(qr.pop_front());
        if (v && exp_rdy && m != '0) push_req(m, d);
    endtask

    function automatic logic [N*DATAW-1:0] rnd_data();
        logic [N*DATAW-1:0] d;
        for (int i = 0; i < N; i++) d[i*DATAW +: DATAW] = $urandom;
        return d;
    endfunction

    task automatic drain();
        for (int i = 0; i < 20 && qf.size() != 0; i++) cycle(1'b0, '0, '0, 1'b1);
        chk("drain_budget", 64'(qf.size()), 64'd0);
        cycle(1'b0, '0, '0, 1'b1);
    endtask

    initial begin
        reset = 1'b1; valid_in = 1'b0; mask_in = '0; data_in = '0; ready_out = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(valid_out_f | valid_out_r), 64'd0);
        chk("rst_first", 64'(first_out_f | first_out_r), 64'd0);
        chk("rst_last",  64'(last_out_f | last_out_r), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_ready_in", 64'(ready_in_f & ready_in_r), 64'd1);

        // Basic order; the reverse instance sees the same request highest lane first.
        cycle(1'b1, 4'b1010, rnd_data(), 1'b1);
        drain();
        cycle(1'b1, 4'b1011, rnd_data(), 1'b1);
        drain();

        // Backpressure with valid_in held high: nothing new may be accepted.
        cycle(1'b1, 4'b0110, rnd_data(), 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 4'b1111, rnd_data(), 1'b0);
        drain();

        // Back-to-back: B accepted on the same edge as A's last fire.
        cycle(1'b1, 4'b0001, rnd_data(), 1'b1);
        cycle(1'b1, 4'b1100, rnd_data(), 1'b1);
        cycle(1'b0, '0, '0, 1'b1);
        cycle(1'b0, '0, '0, 1'b1);
        drain();

        // Zero mask is consumed with no output, then a single-lane request.
        cycle(1'b1, 4'b0000, rnd_data(), 1'b1);
        cycle(1'b1, 4'b1000, rnd_data(), 1'b1);
        drain();

        // Asynchronous reset after two fires of a full request.
        cycle(1'b1, 4'b1111, rnd_data(), 1'b1);
        cycle(1'b0, '0, '0, 1'b1);
        cycle(1'b0, '0, '0, 1'b1);
        @(posedge clk);
        #2;
        valid_in = 1'b0;
        reset = 1'b1;
        #1;
        chk("arst_valid", 64'(valid_out_f | valid_out_r), 64'd0);
        chk("arst_first", 64'(first_out_f | first_out_r), 64'd0);
        chk("arst_last",  64'(last_out_f | last_out_r), 64'd0);
        qf.delete();
        qr.delete();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("arst_ready_in", 64'(ready_in_f & ready_in_r), 64'd1);
        cycle(1'b0, '0, '0, 1'b1);
        cycle(1'b0, '0, '0, 1'b1);

        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 1)), 4'($urandom), rnd_data(),
                  1'($urandom_range(0, 3) != 0));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
